// File: rtl/uart_pkg.sv
// uart_pkg: constants, FSM encoding and helpers shared by the UART
// transmit path (uart_tx_byte serializer and uart_row_tx row sender).
package uart_pkg;

  // 27 MHz clock / 115200 baud
  localparam int CLKS_PER_BIT_DEFAULT = 234;

  localparam logic [7:0] ASCII_CR    = 8'd13;
  localparam logic [7:0] ASCII_LF    = 8'd10;
  localparam logic [7:0] ASCII_SPACE = 8'd32;
  localparam logic [7:0] ASCII_DEL   = 8'd127;
  localparam logic [7:0] ASCII_BS    = 8'd8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SEND  = 3'd3,
    CR    = 3'd4,
    LF    = 3'd5,
    FIN   = 3'd6
  } row_state_t;

  // Control characters and DEL become a space so the remote terminal
  // never sees backspace/erase sequences coming from row content.
  function automatic logic [7:0] printable(input logic [7:0] b);
    logic [7:0] r;
    if ((b < ASCII_SPACE) || (b == ASCII_DEL)) begin
      r = ASCII_SPACE;
    end else begin
      r = b;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// uart_tx_byte: 8N1 serializer for one byte, LSB first.
// Ports:
//   clk_i    - clock, rising edge
//   reset_i  - synchronous active-low reset
//   start_i  - load data_i and begin a frame (ignored while busy_o)
//   data_i   - byte to send
//   busy_o   - frame in progress
//   done_o   - 1-cycle pulse during the last cycle of the stop bit
//   tx_o     - serial line, idle high
module uart_tx_byte
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       tx_o
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_PRELAST = CNT_W'(CLKS_PER_BIT - 2);

  logic             busy_r;
  logic             done_r;
  logic             tx_r;
  logic [CNT_W-1:0] cnt_r;
  logic [3:0]       idx_r;    // 0 = start bit, 1..8 = data, 9 = stop
  logic [7:0]       shift_r;

  // Bit-period counter, bit index and shift register for one frame.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      tx_r    <= 1'b1;
      cnt_r   <= '0;
      idx_r   <= 4'd0;
      shift_r <= 8'd0;
    end else begin
      // Done is raised one cycle early so it coincides with the final
      // stop-bit cycle; the row FSM then moves on exactly at frame end.
      done_r <= busy_r && (idx_r == 4'd9) && (cnt_r == CNT_PRELAST);
      if (!busy_r) begin
        if (start_i) begin
          busy_r  <= 1'b1;
          tx_r    <= 1'b0;
          shift_r <= data_i;
          cnt_r   <= '0;
          idx_r   <= 4'd0;
        end
      end else if (cnt_r == CNT_LAST) begin
        cnt_r <= '0;
        if (idx_r == 4'd9) begin
          busy_r <= 1'b0;
          tx_r   <= 1'b1;
        end else begin
          // Ones are shifted in, so after the 8th data bit the LSB is
          // already the stop-bit level.
          idx_r   <= idx_r + 4'd1;
          tx_r    <= shift_r[0];
          shift_r <= {1'b1, shift_r[7:1]};
        end
      end else begin
        cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign busy_o = busy_r;
  assign done_o = done_r;
  assign tx_o   = tx_r;

endmodule

// File: rtl/uart_row_tx.sv
// uart_row_tx: sends one 16-character row over an 8N1 UART line,
// optionally followed by CR LF.
// Ports:
//   clk_i       - clock, rising edge
//   reset_i     - synchronous active-low reset
//   start_i     - request one row (sampled only in IDLE)
//   charIndex_o - character index presented to the row source
//   char_i      - row source byte, valid 1 cycle after charIndex_o changes
//   busy_o      - row transmission in progress
//   done_o      - 1-cycle pulse when the row has been sent
//   uart_tx_o   - serial line, idle high
module uart_row_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int SEND_CRLF    = 1
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  output logic [3:0] charIndex_o,
  input  logic [7:0] char_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       uart_tx_o
);

  row_state_t state_r;
  row_state_t state_s;
  logic       fetch_cnt_r;   // second FETCH cycle marker
  logic       sent_r;        // CR/LF frame already launched in this state
  logic [3:0] char_index_r;
  logic       busy_r;
  logic       done_r;

  logic       index_inc_s;
  logic       ser_start_s;
  logic [7:0] ser_data_s;
  logic       ser_busy_s;
  logic       ser_done_s;
  logic       ser_tx_s;

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx_byte (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (ser_start_s),
    .data_i  (ser_data_s),
    .busy_o  (ser_busy_s),
    .done_o  (ser_done_s),
    .tx_o    (ser_tx_s)
  );

  // Next-state and serializer control.
  always_comb begin
    state_s     = state_r;
    index_inc_s = 1'b0;
    ser_start_s = 1'b0;
    ser_data_s  = ASCII_SPACE;
    case (state_r)
      IDLE: begin
        if (start_i) begin
          state_s = FETCH;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        if (fetch_cnt_r) begin
          state_s = LOAD;
        end else begin
          state_s = FETCH;
        end
      end
      LOAD: begin
        ser_start_s = 1'b1;
        ser_data_s  = printable(char_i);
        state_s     = SEND;
      end
      SEND: begin
        if (ser_done_s) begin
          if (char_index_r != 4'd15) begin
            index_inc_s = 1'b1;
            state_s     = FETCH;
          end else if (SEND_CRLF != 0) begin
            state_s = CR;
          end else begin
            state_s = FIN;
          end
        end else begin
          state_s = SEND;
        end
      end
      CR: begin
        if (!sent_r && !ser_busy_s) begin
          ser_start_s = 1'b1;
          ser_data_s  = ASCII_CR;
        end else if (sent_r && ser_done_s) begin
          state_s = LF;
        end else begin
          state_s = CR;
        end
      end
      LF: begin
        if (!sent_r && !ser_busy_s) begin
          ser_start_s = 1'b1;
          ser_data_s  = ASCII_LF;
        end else if (sent_r && ser_done_s) begin
          state_s = FIN;
        end else begin
          state_s = LF;
        end
      end
      FIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register, character index and registered status outputs.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r      <= IDLE;
      fetch_cnt_r  <= 1'b0;
      sent_r       <= 1'b0;
      char_index_r <= 4'd0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      fetch_cnt_r <= (state_r == FETCH) ? ~fetch_cnt_r : 1'b0;
      sent_r      <= (state_s != state_r) ? 1'b0 : (sent_r | ser_start_s);
      if ((state_r == IDLE) && start_i) begin
        char_index_r <= 4'd0;
      end else if (index_inc_s) begin
        char_index_r <= char_index_r + 4'd1;
      end
      busy_r <= (state_s != IDLE) && (state_s != FIN);
      done_r <= (state_s == FIN);
    end
  end

  assign charIndex_o = char_index_r;
  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign uart_tx_o   = ser_tx_s;

endmodule
